operand_entry: RTL and testbench

Keypad operand capture for the multiplier datapath. Accepts a decimal operand entered as sign plus BCD digits, and builds the sign-magnitude value digit by digit. On enter, it converts the value to two's complement and offers it to the multiplier through a valid/ready handshake. It is the input-side counterpart of the output sign-magnitude/display path: sign-magnitude in, two's complement out.

---
 rtl/mult_pkg.sv | 16 +
 rtl/operand_entry_decimal_accumulator.sv | 28 ++
 rtl/operand_entry.sv | 109 ++++++++++
 tb/tb_operand_entry.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier front end.
// Holds the keypad code points and the operand-entry state encoding.
package mult_pkg;

  localparam logic [3:0] KEY_SIGN  = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;
  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CONVERT = 2'd1,
    OFFER   = 2'd2
  } entry_state_t;

endpackage

// File: rtl/operand_entry_decimal_accumulator.sv
// decimal_accumulator: combinational m*10 + d with magnitude-limit check.
//   mag_i   : current magnitude (WIDTH-1 bits)
//   digit_i : BCD digit 0..9
//   next_o  : low WIDTH-1 bits of m*10+d (only meaningful when ovf_o = 0)
//   ovf_o   : 1 when m*10+d exceeds 2^(WIDTH-1)-1
module decimal_accumulator #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-2:0] mag_i,
  input  logic [3:0]       digit_i,
  output logic [WIDTH-2:0] next_o,
  output logic             ovf_o
);

  localparam logic [WIDTH+3:0] MAX_MAG = (WIDTH+4)'((1 << (WIDTH-1)) - 1);

  logic [WIDTH+3:0] mag_ext;
  logic [WIDTH+3:0] sum;

  // Computed at WIDTH+4 bits so 10*MAX_MAG + 9 can never wrap before the compare.
  always_comb begin
    mag_ext = {5'b0, mag_i};
    sum     = (mag_ext << 3) + (mag_ext << 1) + {{WIDTH{1'b0}}, digit_i};
    ovf_o   = (sum > MAX_MAG);
    next_o  = sum[WIDTH-2:0];
  end

endmodule

// File: rtl/operand_entry.sv
// operand_entry: keypad operand capture for the multiplier datapath.
// Builds a sign-magnitude decimal entry from key strobes, converts it to
// two's complement on enter and offers it over a valid/ready handshake.
//   clk, reset      : clock (rising edge), asynchronous active-low reset
//   key_valid/code  : one-cycle key strobe and its code
//   operand_ready   : downstream accepts the operand
//   operand/_valid  : offered two's complement operand
//   entry_sign/magnitude/error : live entry state for display echo
module operand_entry
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             operand_ready,
  output logic [WIDTH-1:0] operand,
  output logic             operand_valid,
  output logic             entry_sign,
  output logic [WIDTH-2:0] entry_magnitude,
  output logic             entry_error
);

  entry_state_t     state_q;
  logic [WIDTH-1:0] operand_q;
  logic [WIDTH-1:0] operand_d;
  logic             valid_q;
  logic             sign_q;
  logic [WIDTH-2:0] mag_q;
  logic             err_q;

  logic [WIDTH-2:0] acc_next;
  logic             acc_ovf;

  decimal_accumulator #(.WIDTH(WIDTH)) u_acc (
    .mag_i   (mag_q),
    .digit_i (key_code),
    .next_o  (acc_next),
    .ovf_o   (acc_ovf)
  );

  // Sign-magnitude to two's complement; -0 collapses to 0.
  always_comb begin
    operand_d = '0;
    if (mag_q != '0) begin
      if (sign_q) operand_d = ~{1'b0, mag_q} + WIDTH'(1);
      else        operand_d = {1'b0, mag_q};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ENTRY;
      operand_q <= '0;
      valid_q   <= 1'b0;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        ENTRY: begin
          if (key_valid) begin
            if (key_code <= KEY_DIGIT_MAX) begin
              if (acc_ovf) begin
                err_q <= 1'b1;
              end else begin
                mag_q <= acc_next;
                err_q <= 1'b0;
              end
            end else if (key_code == KEY_SIGN) begin
              sign_q <= ~sign_q;
            end else if (key_code == KEY_CLEAR) begin
              sign_q <= 1'b0;
              mag_q  <= '0;
              err_q  <= 1'b0;
            end else if (key_code == KEY_ENTER) begin
              state_q <= CONVERT;
            end
          end
        end
        CONVERT: begin
          operand_q <= operand_d;
          valid_q   <= 1'b1;
          state_q   <= OFFER;
        end
        OFFER: begin
          // Keys arriving here are dropped; only the handshake moves us on.
          if (operand_ready) begin
            valid_q <= 1'b0;
            sign_q  <= 1'b0;
            mag_q   <= '0;
            err_q   <= 1'b0;
            state_q <= ENTRY;
          end
        end
        default: state_q <= ENTRY;
      endcase
    end
  end

  assign operand         = operand_q;
  assign operand_valid   = valid_q;
  assign entry_sign      = sign_q;
  assign entry_magnitude = mag_q;
  assign entry_error     = err_q;

endmodule

// File: tb/tb_operand_entry.sv
module tb_operand_entry;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       operand_ready = 1'b0;
  logic [7:0] operand;
  logic       operand_valid;
  logic       entry_sign;
  logic [6:0] entry_magnitude;
  logic       entry_error;

  operand_entry #(.WIDTH(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .key_valid       (key_valid),
    .key_code        (key_code),
    .operand_ready   (operand_ready),
    .operand         (operand),
    .operand_valid   (operand_valid),
    .entry_sign      (entry_sign),
    .entry_magnitude (entry_magnitude),
    .entry_error     (entry_error)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the decimal entry.
  int m_sign = 0;
  int m_mag  = 0;
  int m_err  = 0;
  int exp_q[$];

  function automatic void model_clear();
    m_sign = 0; m_mag = 0; m_err = 0;
  endfunction

  function automatic void model_key(input int code);
    if (code <= 9) begin
      if (m_mag * 10 + code <= 127) begin
        m_mag = m_mag * 10 + code;
        m_err = 0;
      end else begin
        m_err = 1;
      end
    end else if (code == 10) begin
      m_sign = 1 - m_sign;
    end else if (code == 11) begin
      model_clear();
    end
  endfunction

  task automatic chk_entry(input string tag);
    chk({tag, "_sign"}, int'(entry_sign), m_sign);
    chk({tag, "_mag"},  int'(entry_magnitude), m_mag);
    chk({tag, "_err"},  int'(entry_error), m_err);
  endtask

  // Called at a negedge: check entry state, then strobe a key for one edge.
  task automatic key(input int code);
    chk_entry("entry");
    key_valid = 1'b1;
    key_code  = 4'(code);
    model_key(code);
    @(negedge clk);
  endtask

  task automatic idle();
    key_valid = 1'b0;
    @(negedge clk);
  endtask

  // Enter, then hold ready low for 'delay' cycles, optionally strobing keys
  // that must be dropped, then complete the handshake.
  task automatic enter_op(input int delay, input bit noisy, input bit ready_early);
    int noise[3] = '{3, 11, 12};
    chk_entry("pre_enter");
    operand_ready = ready_early;
    key_valid = 1'b1;
    key_code  = 4'hC;
    exp_q.push_back(m_sign ? ((-m_mag) & 8'hFF) : m_mag);
    @(negedge clk);
    key_valid = 1'b0;
    chk("valid_after_enter_edge", int'(operand_valid), 0);
    @(negedge clk);
    chk("valid_latency", int'(operand_valid), 1);
    for (int i = 0; i < delay; i++) begin
      operand_ready = 1'b0;
      key_valid = noisy;
      key_code  = 4'(noisy ? noise[i % 3] : $urandom_range(0, 15));
      @(negedge clk);
      chk("valid_held", int'(operand_valid), 1);
    end
    key_valid = 1'b0;
    operand_ready = 1'b1;
    @(negedge clk);
    chk("valid_after_handshake", int'(operand_valid), 0);
    model_clear();
    chk_entry("post_handshake");
    operand_ready = $urandom_range(0, 1);
  endtask

  // Monitor: pops the scoreboard when a new operand is offered, and checks
  // that an offered operand stays put until accepted.
  bit         prev_v = 1'b0;
  logic [7:0] held   = 8'h00;
  always @(negedge clk) begin
    if (!reset) begin
      prev_v = 1'b0;
    end else begin
      if (operand_valid && !prev_v) begin
        if (exp_q.size() == 0) chk("unexpected_offer", 1, 0);
        else chk("operand", int'(operand), exp_q.pop_front());
        held = operand;
      end else if (operand_valid) begin
        chk("operand_stable", int'(operand), int'(held));
      end
      prev_v = operand_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int nk;
    int c;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_operand", int'(operand), 0);
    chk("rst_valid", int'(operand_valid), 0);
    chk_entry("rst");
    reset = 1'b1;
    @(negedge clk);

    // 123 with ready already high -> 0x7B
    key(1); key(2); key(3);
    enter_op(0, 1'b0, 1'b1);
    // -45 -> 0xD3
    key(10); key(4); key(5);
    enter_op(1, 1'b0, 1'b0);
    // 128 rejected, then 127
    key(1); key(2); key(8); key(7);
    enter_op(2, 1'b0, 1'b0);
    // -0 -> 0, and double toggle
    key(10);
    enter_op(0, 1'b0, 1'b0);
    key(10); key(10); key(9);
    enter_op(0, 1'b0, 1'b0);
    // -100 held 5 cycles with 3,B,C strobed meanwhile
    key(10); key(1); key(0); key(0);
    enter_op(5, 1'b1, 1'b0);
    // clear and ignored codes
    key(10); key(6); key(13); key(15); key(11); key(2); idle();
    enter_op(0, 1'b0, 1'b0);

    // Reset during OFFER
    key(7); key(7); idle();
    chk_entry("pre_enter_rst");
    operand_ready = 1'b0;
    key_valid = 1'b1; key_code = 4'hC;
    exp_q.push_back(77);
    @(negedge clk);
    key_valid = 1'b0;
    @(negedge clk);
    chk("valid_before_rst", int'(operand_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_valid", int'(operand_valid), 0);
    chk("async_rst_operand", int'(operand), 0);
    model_clear();
    chk_entry("async_rst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    key(5);
    enter_op(0, 1'b0, 1'b0);

    // Randomized entries
    for (int t = 0; t < 60; t++) begin
      nk = $urandom_range(0, 7);
      for (int k = 0; k < nk; k++) begin
        c = $urandom_range(0, 15);
        if (c == 12) c = $urandom_range(0, 9);
        key(c);
        if ($urandom_range(0, 3) == 0) idle();
      end
      enter_op($urandom_range(0, 4), 1'b0, $urandom_range(0, 1));
    end

    idle(); idle();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
